// File: rtl/dht11_ctrl.sv
// DHT11 single-wire transaction controller, paced by a 1 us tick.
// Optional post-transaction cool-down is enabled by defining DHT11_MIN_INTERVAL_EN.
module dht11_ctrl #(
  parameter int unsigned START_LOW_US    = 18000,
  parameter int unsigned TIMEOUT_US      = 100,
  parameter int unsigned BIT_THRESH_US   = 40,
  parameter int unsigned MIN_INTERVAL_US = 1000000
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       tick_1us,
  input  logic       start,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] tmp_int,
  output logic [7:0] tmp_dec,
  output logic       valid,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code
);

  typedef enum logic [3:0] {
    IDLE,
    START_LOW,
    WAIT_RESP,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK,
    ERROR
`ifdef DHT11_MIN_INTERVAL_EN
    , COOLDOWN
`endif
  } state_t;

  localparam logic [14:0] START_LAST = 15'(START_LOW_US - 1);
  localparam logic [14:0] TIMEOUT    = 15'(TIMEOUT_US);
  localparam logic [14:0] THRESH     = 15'(BIT_THRESH_US);

`ifdef DHT11_MIN_INTERVAL_EN
  localparam state_t DONE = COOLDOWN;
  localparam int unsigned CW = (MIN_INTERVAL_US > 1) ? $clog2(MIN_INTERVAL_US) : 1;
  localparam logic [CW-1:0] COOL_LAST = CW'(MIN_INTERVAL_US - 1);
  logic [CW-1:0] cool_cnt;
  logic          pending;
`else
  localparam state_t DONE = IDLE;
  logic unused_min_interval;
  assign unused_min_interval = ^MIN_INTERVAL_US;
`endif

  state_t      state, state_next;
  logic        sync1, sync2, line_q;
  logic        rise, fall;
  logic [14:0] us_cnt;
  logic [5:0]  bit_cnt;
  logic [39:0] shreg;
  logic [1:0]  fail_code, fail_code_next;
  logic        shift_en, accept, timeout;
  logic [7:0]  sum;
  logic        sum_ok;

  assign rise    = sync2 & ~line_q;
  assign fall    = ~sync2 & line_q;
  assign timeout = (us_cnt >= TIMEOUT);
  assign sum     = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];
  assign sum_ok  = (sum == shreg[7:0]);
  assign dht_oe  = (state == START_LOW);
  assign busy    = (state != IDLE);

  // Edge checks precede timeout checks so a simultaneous edge wins.
  always_comb begin
    state_next     = state;
    fail_code_next = fail_code;
    shift_en       = 1'b0;
    accept         = 1'b0;
    case (state)
      IDLE: begin
`ifdef DHT11_MIN_INTERVAL_EN
        if (start || pending) begin
`else
        if (start) begin
`endif
          accept     = 1'b1;
          state_next = START_LOW;
        end
      end
      START_LOW: if (tick_1us && us_cnt == START_LAST) state_next = WAIT_RESP;
      WAIT_RESP: begin
        if (fall) state_next = RESP_LOW;
        else if (timeout) begin state_next = ERROR; fail_code_next = 2'b01; end
      end
      RESP_LOW: begin
        if (rise) state_next = RESP_HIGH;
        else if (timeout) begin state_next = ERROR; fail_code_next = 2'b01; end
      end
      RESP_HIGH: begin
        if (fall) state_next = BIT_LOW;
        else if (timeout) begin state_next = ERROR; fail_code_next = 2'b01; end
      end
      BIT_LOW: begin
        if (rise) state_next = BIT_HIGH;
        else if (timeout) begin state_next = ERROR; fail_code_next = 2'b10; end
      end
      BIT_HIGH: begin
        if (fall) begin
          shift_en   = 1'b1;
          state_next = (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
        end else if (timeout) begin
          state_next     = ERROR;
          fail_code_next = 2'b10;
        end
      end
      CHECK: begin
        if (sum_ok) state_next = DONE;
        else begin state_next = ERROR; fail_code_next = 2'b11; end
      end
      ERROR: state_next = DONE;
`ifdef DHT11_MIN_INTERVAL_EN
      COOLDOWN: if (tick_1us && cool_cnt == COOL_LAST) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fail_code <= '0;
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_q    <= 1'b1;
      us_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      hum_int   <= '0;
      hum_dec   <= '0;
      tmp_int   <= '0;
      tmp_dec   <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
    end else begin
      state     <= state_next;
      fail_code <= fail_code_next;
      sync1     <= dht_in;
      sync2     <= sync1;
      line_q    <= sync2;

      if (state_next != state) us_cnt <= '0;
      else if (tick_1us && us_cnt != '1) us_cnt <= us_cnt + 15'd1;

      if (state == RESP_HIGH) bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 6'd1;

      if (shift_en) shreg <= {shreg[38:0], (us_cnt > THRESH)};

      valid <= (state == CHECK) && sum_ok;
      if (state == CHECK && sum_ok) begin
        hum_int <= shreg[39:32];
        hum_dec <= shreg[31:24];
        tmp_int <= shreg[23:16];
        tmp_dec <= shreg[15:8];
      end

      if (accept) begin
        err      <= 1'b0;
        err_code <= '0;
      end else if (state == ERROR) begin
        err      <= 1'b1;
        err_code <= fail_code;
      end
    end
  end

`ifdef DHT11_MIN_INTERVAL_EN
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cool_cnt <= '0;
      pending  <= 1'b0;
    end else begin
      if (state != COOLDOWN) cool_cnt <= '0;
      else if (tick_1us) cool_cnt <= cool_cnt + 1'b1;

      if (accept) pending <= 1'b0;
      else if (state == COOLDOWN && start) pending <= 1'b1;
    end
  end
`endif

endmodule
